exec_datapath: RTL and testbench

//  Execution datapath at the far end of the control-unit interface. Accepts the decoded

---
 rtl/exec_datapath.sv | 100 ++++++++++
 tb/tb_exec_datapath.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_datapath.sv
// exec_datapath: latches one decoded instruction, runs the ALU, optionally accesses a 2**ADDR_BITS-word data memory, returns result2; ports clk, rst (async active-low), op_valid, operand1, operand2, offset, opcode, sel1, sel3, w_r in; busy, result_valid, result2, zero_flag, carry_flag out
module exec_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic                  busy,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero_flag,
  output logic                  carry_flag
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MEM = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] a_q, b_q, o_q, bb, alu_res;
  logic [3:0] op_q;
  logic s1_q, s3_q, wr_q, alu_c;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH:0] add_x, sub_x, inc_x, dec_x;
  assign bb = s3_q ? o_q : b_q;
  assign add_x = {1'b0, a_q} + {1'b0, bb};
  assign sub_x = {1'b0, a_q} - {1'b0, bb};
  assign inc_x = {1'b0, a_q} + (DATA_WIDTH+1)'(1);
  assign dec_x = {1'b0, a_q} - (DATA_WIDTH+1)'(1);
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
  always_comb begin
    alu_res = '0;
    alu_c = 1'b0;
    case (op_q)
      4'b0000: {alu_c, alu_res} = add_x;
      4'b0001: {alu_c, alu_res} = sub_x;
      4'b0010: alu_res = a_q & bb;
      4'b0011: alu_res = a_q | bb;
      4'b0100: alu_res = a_q ^ bb;
      4'b0101: alu_res = ~a_q;
      4'b0110: alu_res = a_q << bb[2:0];
      4'b0111: alu_res = a_q >> bb[2:0];
      4'b1000: {alu_c, alu_res} = inc_x;
      4'b1001: {alu_c, alu_res} = dec_x;
      4'b1010: alu_res = a_q;
      4'b1011: alu_res = bb;
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      o_q <= '0;
      op_q <= '0;
      s1_q <= 1'b0;
      s3_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      result2 <= '0;
      zero_flag <= 1'b0;
      carry_flag <= 1'b0;
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          a_q <= operand1;
          b_q <= operand2;
          o_q <= offset;
          op_q <= opcode;
          s1_q <= sel1;
          s3_q <= sel3;
          wr_q <= w_r;
          state <= EXEC;
        end
        EXEC: begin
          addr_q <= alu_res[ADDR_BITS-1:0];
          zero_flag <= alu_res == '0;
          carry_flag <= alu_c;
          if (s1_q) result2 <= alu_res;
          state <= s1_q ? DONE : MEM;
        end
        MEM: begin
          // Loads see the pre-write word; stores echo the stored data back for write-back.
          if (wr_q) mem[addr_q] <= b_q;
          result2 <= wr_q ? b_q : mem[addr_q];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: table vectors, hand sequences and randomized ops against a reference model for exec_datapath
module tb_exec_datapath;
  logic clk = 1'b0, rst = 1'b0, op_valid = 1'b0;
  logic [7:0] operand1 = '0, operand2 = '0, offset = '0;
  logic [3:0] opcode = '0;
  logic sel1 = 1'b0, sel3 = 1'b0, w_r = 1'b0;
  logic busy, result_valid, zero_flag, carry_flag;
  logic [7:0] result2;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [32];
  typedef struct {
    logic [7:0] a, b, o;
    logic [3:0] op;
    logic s3;
    logic [7:0] r;
    logic z, c;
  } rec_t;
  rec_t tbl [16];
  exec_datapath dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .operand1(operand1), .operand2(operand2),
    .offset(offset), .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .busy(busy), .result_valid(result_valid), .result2(result2),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                  output logic [7:0] r, output logic c);
    int x, ai, bi;
    ai = int'(a);
    bi = int'(b);
    x = 0;
    c = 1'b0;
    case (op)
      4'd0: begin x = ai + bi; c = x > 255; end
      4'd1: begin x = ai - bi; c = x < 0; end
      4'd2: x = ai & bi;
      4'd3: x = ai | bi;
      4'd4: x = ai ^ bi;
      4'd5: x = 255 - ai;
      4'd6: x = ai * (2 ** (bi % 8));
      4'd7: x = ai / (2 ** (bi % 8));
      4'd8: begin x = ai + 1; c = x > 255; end
      4'd9: begin x = ai - 1; c = x < 0; end
      4'd10: x = ai;
      4'd11: x = bi;
      default: x = 0;
    endcase
    r = x[7:0];
  endfunction
  task automatic set_fields(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                            input logic [3:0] op, input logic s1, input logic s3, input logic w);
    operand1 = a; operand2 = b; offset = o; opcode = op; sel1 = s1; sel3 = s3; w_r = w;
  endtask
  // Called at a negedge; returns at the negedge where result_valid is seen (or the bound expires).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                       input logic [3:0] op, input logic s1, input logic s3, input logic w,
                       output int lat);
    int g = 0;
    while (busy && g < 20) begin @(negedge clk); g++; end
    set_fields(a, b, o, op, s1, s3, w);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 10) begin @(negedge clk); lat++; end
  endtask
  initial begin
    int lat, hits;
    logic [7:0] r, exp, a, b, o;
    logic [3:0] op;
    logic c, s1, s3, w;
    tbl[0]  = '{8'hF0, 8'h20, 8'h00, 4'd0,  1'b0, 8'h10, 1'b0, 1'b1};
    tbl[1]  = '{8'h05, 8'h05, 8'h00, 4'd1,  1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{8'h03, 8'h05, 8'h00, 4'd1,  1'b0, 8'hFE, 1'b0, 1'b1};
    tbl[3]  = '{8'hF0, 8'h3C, 8'h00, 4'd2,  1'b0, 8'h30, 1'b0, 1'b0};
    tbl[4]  = '{8'hF0, 8'h0F, 8'h00, 4'd3,  1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{8'hFF, 8'h0F, 8'h00, 4'd4,  1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[6]  = '{8'h0F, 8'h00, 8'h00, 4'd5,  1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[7]  = '{8'h81, 8'h01, 8'h00, 4'd6,  1'b0, 8'h02, 1'b0, 1'b0};
    tbl[8]  = '{8'h81, 8'h01, 8'h00, 4'd7,  1'b0, 8'h40, 1'b0, 1'b0};
    tbl[9]  = '{8'hFF, 8'h00, 8'h00, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 8'h00, 4'd9,  1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[11] = '{8'h5A, 8'h11, 8'h00, 4'd10, 1'b0, 8'h5A, 1'b0, 1'b0};
    tbl[12] = '{8'h5A, 8'h11, 8'h77, 4'd11, 1'b1, 8'h77, 1'b0, 1'b0};
    tbl[13] = '{8'h12, 8'h34, 8'h00, 4'd15, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[14] = '{8'h12, 8'h34, 8'h00, 4'd12, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[15] = '{8'h10, 8'hFF, 8'h05, 4'd0,  1'b1, 8'h15, 1'b0, 1'b0};
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset result2", result2, 0);
    chk("reset zero", zero_flag, 0);
    chk("reset carry", carry_flag, 0);
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].op, 1'b1, tbl[i].s3, 1'b0, lat);
      chk($sformatf("tbl%0d latency", i), lat, 2);
      chk($sformatf("tbl%0d result2", i), result2, tbl[i].r);
      chk($sformatf("tbl%0d zero", i), zero_flag, tbl[i].z);
      chk($sformatf("tbl%0d carry", i), carry_flag, tbl[i].c);
      @(negedge clk);
      chk($sformatf("tbl%0d pulse", i), result_valid, 0);
      chk($sformatf("tbl%0d idle", i), busy, 0);
    end
    issue(8'h04, 8'hA5, 8'h03, 4'd0, 1'b0, 1'b1, 1'b1, lat);
    chk("store latency", lat, 3);
    chk("store result2", result2, 8'hA5);
    issue(8'h05, 8'h00, 8'h02, 4'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("load latency", lat, 3);
    chk("load result2", result2, 8'hA5);
    issue(8'h1F, 8'h3C, 8'h01, 4'd0, 1'b0, 1'b1, 1'b1, lat);
    chk("wrap store result2", result2, 8'h3C);
    issue(8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("wrap load result2", result2, 8'h3C);
    chk("wrap load zero", zero_flag, 1);
    // Pulse a SUB while a load is busy: it must be dropped.
    @(negedge clk);
    set_fields(8'h05, 8'h00, 8'h02, 4'd0, 1'b0, 1'b1, 1'b0);
    op_valid = 1'b1;
    @(negedge clk);
    set_fields(8'h05, 8'h05, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("busy load valid", result_valid, 1);
    chk("busy load result2", result2, 8'hA5);
    hits = 0;
    repeat (4) begin @(negedge clk); hits += int'(busy | result_valid); end
    chk("pulsed op ignored", hits, 0);
    // Hold op_valid: the SUB is taken on the first IDLE cycle after the load.
    set_fields(8'h05, 8'h00, 8'h02, 4'd0, 1'b0, 1'b1, 1'b0);
    op_valid = 1'b1;
    @(negedge clk);
    set_fields(8'h05, 8'h05, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("held load valid", result_valid, 1);
    chk("held load result2", result2, 8'hA5);
    @(negedge clk);
    chk("held idle gap", busy, 0);
    @(negedge clk);
    chk("held sub accepted", busy, 1);
    op_valid = 1'b0;
    @(negedge clk);
    chk("held sub valid", result_valid, 1);
    chk("held sub result2", result2, 0);
    chk("held sub zero", zero_flag, 1);
    chk("held sub carry", carry_flag, 0);
    // Abort a store to addr 7 during EXEC.
    @(negedge clk);
    set_fields(8'h07, 8'h99, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("abort in exec", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort result_valid", result_valid, 0);
    chk("abort result2", result2, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    hits = 0;
    repeat (4) begin @(negedge clk); hits += int'(result_valid); end
    chk("abort no result_valid", hits, 0);
    issue(8'h07, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("abort mem7", result2, 0);
    issue(8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("reset cleared mem0", result2, 0);
    for (int i = 0; i < 60; i++) begin
      a = (i % 2 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      b = 8'($urandom);
      o = 8'($urandom_range(0, 7));
      op = (i % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      s1 = 1'($urandom);
      s3 = 1'($urandom);
      w = 1'($urandom);
      ref_alu(a, s3 ? o : b, op, r, c);
      exp = r;
      if (!s1) begin
        exp = w ? b : mem_m[r[4:0]];
        if (w) mem_m[r[4:0]] = b;
      end
      issue(a, b, o, op, s1, s3, w, lat);
      chk($sformatf("rnd%0d latency", i), lat, s1 ? 2 : 3);
      chk($sformatf("rnd%0d result2", i), result2, exp);
      chk($sformatf("rnd%0d zero", i), zero_flag, r == 8'h00);
      chk($sformatf("rnd%0d carry", i), carry_flag, c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
